// File: rtl/run_sequencer.sv
// Preloads a data memory from a byte stream, pulses the core start, waits for its halt
// (with a cycle-count timeout), then streams a fixed window of results back out.
module run_sequencer #(
    parameter logic [7:0]  LOAD_BASE = 8'd0,
    parameter logic [7:0]  OUT_BASE  = 8'd64,
    parameter int          OUT_LEN   = 32,
    parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        core_start,
    input  logic        core_ack,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DUMP} state_t;

    localparam logic [8:0] LAST_IDX = 9'(OUT_LEN - 1);

    state_t     state;
    logic [7:0] load_idx;
    logic [7:0] dump_idx;
    logic       start_cnt;
    logic       accept;
    logic       dump_last;

    assign accept    = (state == LOAD) && in_valid;
    assign dump_last = (state == DUMP) && ({1'b0, dump_idx} == LAST_IDX);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            load_idx   <= 8'd0;
            dump_idx   <= 8'd0;
            start_cnt  <= 1'b0;
            run_cycles <= 32'd0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= LOAD;
                        load_idx <= 8'd0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        load_idx <= load_idx + 8'd1;
                        if (in_last) begin
                            state      <= START;
                            start_cnt  <= 1'b0;
                            run_cycles <= 32'd0;
                            timeout    <= 1'b0;
                        end
                    end
                end
                START: begin
                    if (start_cnt)
                        state <= RUN;
                    else
                        start_cnt <= 1'b1;
                end
                // Ack takes priority over the timeout when both land in the same cycle.
                RUN: begin
                    if (core_ack) begin
                        state    <= DUMP;
                        dump_idx <= 8'd0;
                    end else if (run_cycles == TIMEOUT) begin
                        timeout  <= 1'b1;
                        state    <= DUMP;
                        dump_idx <= 8'd0;
                    end else begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        if (dump_last)
                            state <= IDLE;
                        else
                            dump_idx <= dump_idx + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'd0;
        mem_wdata  = 8'd0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'd0;
        out_last   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                mem_we    = accept;
                mem_addr  = LOAD_BASE + load_idx;
                mem_wdata = accept ? in_data : 8'd0;
            end
            START: core_start = 1'b1;
            DUMP: begin
                out_valid = 1'b1;
                mem_addr  = OUT_BASE + dump_idx;
                out_data  = mem_rdata;
                out_last  = dump_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed-plus-random bench for run_sequencer against a byte-level memory model.
module tb_run_sequencer;

    localparam logic [7:0]  LOAD_B = 8'd0;
    localparam logic [7:0]  OUT_B  = 8'd64;
    localparam int          OUT_N  = 32;
    localparam logic [31:0] TMO    = 32'd20;

    typedef logic [7:0] bq_t[$];

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        core_ack = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, mem_we, core_start, out_valid, out_last, busy, timeout;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, out_data;
    logic [31:0] run_cycles;

    logic [7:0]  mem [256];
    logic [7:0]  golden [256];
    logic        fill_mem = 1'b1;
    int unsigned seed;

    int tests = 0;
    int failed = 0;
    int rc;
    logic exp_t;

    run_sequencer #(.LOAD_BASE(LOAD_B), .OUT_BASE(OUT_B), .OUT_LEN(OUT_N), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_start(core_start), .core_ack(core_ack),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] fillVal(input int a);
        return 8'((a * 37) ^ int'(seed));
    endfunction

    always @(posedge Clk) begin
        if (fill_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= fillVal(a);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, settle, then the caller checks.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic ack, input logic rdy);
        @(negedge Clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        core_ack  = ack;
        out_ready = rdy;
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_core_start"}, 32'(core_start), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_run_cycles"}, run_cycles, 32'd0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic doReset(input string tag);
        @(negedge Clk);
        Reset = 1'b0;
        in_valid = 1'b0;
        core_ack = 1'b0;
        out_ready = 1'b0;
        @(negedge Clk);
        #1;
        checkResetState(tag);
        Reset = 1'b1;
    endtask

    task automatic loadPhase(input bq_t q);
        int i;
        int n;
        n = q.size();
        applyStimulus(1'b1, q[0], n == 1, 1'b0, 1'b0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_mem_we", 32'(mem_we), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        i = 0;
        while (i < n) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
                checkOutput("load_gap_in_ready", 32'(in_ready), 32'd1);
                checkOutput("load_gap_mem_we", 32'(mem_we), 32'd0);
            end else begin
                applyStimulus(1'b1, q[i], i == n - 1, 1'b0, 1'b0);
                checkOutput("load_in_ready", 32'(in_ready), 32'd1);
                checkOutput("load_mem_we", 32'(mem_we), 32'd1);
                checkOutput("load_mem_addr", 32'(mem_addr), 32'(8'(LOAD_B + i)));
                checkOutput("load_mem_wdata", 32'(mem_wdata), 32'(q[i]));
                golden[8'(LOAD_B + i)] = q[i];
                i++;
            end
        end
    endtask

    task automatic startPhase();
        applyStimulus(1'b0, 8'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        checkOutput("start1_core_start", 32'(core_start), 32'd1);
        checkOutput("start1_in_ready", 32'(in_ready), 32'd0);
        checkOutput("start1_busy", 32'(busy), 32'd1);
        checkOutput("start1_run_cycles", run_cycles, 32'd0);
        checkOutput("start1_timeout", 32'(timeout), 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        checkOutput("start2_core_start", 32'(core_start), 32'd1);
    endtask

    task automatic runPhase(input int ack_at, input int abort_at, output bit aborted);
        bit   done;
        logic ack;
        rc = 0;
        exp_t = 1'b0;
        done = 0;
        aborted = 0;
        for (int cyc = 0; cyc < 100 && !done && !aborted; cyc++) begin
            if (cyc == abort_at) begin
                doReset("rst_run");
                aborted = 1;
            end else begin
                ack = (ack_at >= 0) && (rc == ack_at);
                applyStimulus(1'b0, 8'd0, 1'b0, ack, 1'b0);
                checkOutput("run_core_start", 32'(core_start), 32'd0);
                checkOutput("run_out_valid", 32'(out_valid), 32'd0);
                checkOutput("run_in_ready", 32'(in_ready), 32'd0);
                checkOutput("run_run_cycles", run_cycles, 32'(rc));
                if (ack) done = 1;
                else if (rc == int'(TMO)) begin
                    exp_t = 1'b1;
                    done = 1;
                end else rc++;
            end
        end
    endtask

    task automatic dumpPhase(input bit toggle, input int abort_at);
        bit   done;
        bit   aborted;
        logic rdy;
        int   j;
        j = 0;
        done = 0;
        aborted = 0;
        for (int cyc = 0; cyc < 400 && !done && !aborted; cyc++) begin
            if (cyc == abort_at) begin
                doReset("rst_dump");
                aborted = 1;
            end else begin
                rdy = toggle ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 2) != 0);
                applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, rdy);
                checkOutput("dump_out_valid", 32'(out_valid), 32'd1);
                checkOutput("dump_out_data", 32'(out_data), 32'(golden[8'(OUT_B + j)]));
                checkOutput("dump_out_last", 32'(out_last), 32'(j == OUT_N - 1));
                checkOutput("dump_mem_we", 32'(mem_we), 32'd0);
                checkOutput("dump_in_ready", 32'(in_ready), 32'd0);
                checkOutput("dump_run_cycles", run_cycles, 32'(rc));
                checkOutput("dump_timeout", 32'(timeout), 32'(exp_t));
                if (rdy) begin
                    if (j == OUT_N - 1) done = 1;
                    else j++;
                end
            end
        end
        if (!aborted) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("post_busy", 32'(busy), 32'd0);
            checkOutput("post_out_valid", 32'(out_valid), 32'd0);
            checkOutput("post_run_cycles", run_cycles, 32'(rc));
            checkOutput("post_timeout", 32'(timeout), 32'(exp_t));
        end
    endtask

    function automatic bq_t randomBytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic fullRun(input bq_t q, input int ack_at, input bit toggle);
        bit ab;
        loadPhase(q);
        startPhase();
        runPhase(ack_at, -1, ab);
        dumpPhase(toggle, -1);
    endtask

    initial begin
        bq_t q;
        bit  ab;
        seed = $urandom;
        for (int a = 0; a < 256; a++) golden[a] = fillVal(a);
        @(negedge Clk);
        fill_mem = 1'b0;
        in_valid = 1'b1;
        @(negedge Clk);
        #1;
        checkResetState("por");
        in_valid = 1'b0;
        Reset = 1'b1;

        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        fullRun(q, 10, 1'b0);
        fullRun(randomBytes(6), $urandom_range(3, 15), 1'b1);
        fullRun(randomBytes(5), -1, 1'b0);
        fullRun(randomBytes(3), int'(TMO), 1'b0);

        loadPhase(randomBytes(4));
        startPhase();
        runPhase(-1, 5, ab);
        fullRun(randomBytes(7), 7, 1'b0);

        loadPhase(randomBytes(4));
        startPhase();
        runPhase(4, -1, ab);
        dumpPhase(1'b0, 10);
        fullRun(randomBytes(2), 1, 1'b1);

        fullRun(randomBytes(258), 2, 1'b0);
        for (int t = 0; t < 3; t++)
            fullRun(randomBytes($urandom_range(1, 40)), $urandom_range(0, 25), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter LOAD_BASE, default 8'd0, first data-memory address written by the preload stream.
REQ-002 Parameter OUT_BASE, default 8'd64, first data-memory address read back after the run.
REQ-003 Parameter OUT_LEN, default 32, number of result bytes streamed out (legal range 1..256).
REQ-004 Parameter TIMEOUT, default 32'd1_000_000, maximum run cycles before abort.
REQ-005 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-006 Reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge Clk.
REQ-007 in_valid  input  1  preload byte valid.
REQ-008 in_data  input  8  preload byte.
REQ-009 in_last  input  1  marks final preload byte.
REQ-010 in_ready  output  1  preload byte accepted when in_valid && in_ready.
REQ-011 mem_we  output  1  data-memory write strobe.
REQ-012 mem_addr  output  8  data-memory address.
REQ-013 mem_wdata  output  8  data-memory write data.
REQ-014 mem_rdata  input  8  data-memory read data, combinational from mem_addr.
REQ-015 core_start  output  1  drives the core Start input.
REQ-016 core_ack  input  1  core Ack (halt) output.
REQ-017 out_valid  output  1  result byte valid.
REQ-018 out_data  output  8  result byte.
REQ-019 out_last  output  1  marks final result byte.
REQ-020 out_ready  input  1  result byte consumed when out_valid && out_ready.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 timeout  output  1  sticky, set when the last run aborted.
REQ-023 run_cycles  output  32  cycles spent in RUN for the last run.

Function
REQ-024 FSM states SHALL be IDLE, LOAD, START, RUN, DUMP; encoding free.
REQ-025 IDLE: in_ready=0, mem_we=0, mem_addr=0; on in_valid=1 go LOAD and clear the load index k to 0; the byte is not consumed in IDLE.
REQ-026 LOAD: in_ready=1; each accepted byte drives mem_we=1, mem_addr=LOAD_BASE+k (mod 256), mem_wdata=in_data in the same cycle; k increments per accepted byte.
REQ-027 LOAD: an accepted byte with in_last=1 SHALL be written, then the FSM goes START; more than 256 bytes wraps addresses mod 256 with no error.
REQ-028 START: core_start=1 for exactly 2 consecutive cycles, then RUN; entering START clears run_cycles and timeout; core_ack is ignored in START.
REQ-029 RUN: core_start=0; run_cycles increments by 1 each cycle in which core_ack=0.
REQ-030 RUN: core_ack=1 goes DUMP next cycle; run_cycles holds its value.
REQ-031 RUN: when run_cycles reaches TIMEOUT with core_ack=0, set timeout=1 and go DUMP; if core_ack=1 in that same cycle, ack wins and timeout stays 0.
REQ-032 DUMP: clear dump index j on entry; out_valid=1, mem_addr=OUT_BASE+j (mod 256), out_data=mem_rdata, out_last=(j==OUT_LEN-1); mem_we=0.
REQ-033 DUMP: j advances only on out_valid && out_ready; out_data/out_last SHALL remain stable while out_ready=0.
REQ-034 DUMP: the transfer with out_last=1 returns the FSM to IDLE next cycle.
REQ-035 run_cycles and timeout SHALL hold after the run until the next START entry.
REQ-036 in_ready SHALL be 0 in START, RUN, DUMP; out_valid SHALL be 0 outside DUMP.

Reset
REQ-037 Reset=0 at a clock edge, in any state including mid-LOAD/RUN/DUMP, SHALL force IDLE, k=j=0, run_cycles=0, timeout=0.
REQ-038 During and after reset: in_ready, mem_we, core_start, out_valid, out_last, busy = 0; mem_addr, mem_wdata, out_data = 0.

Verification
REQ-039 Load 4 bytes 0x11,0x22,0x33,0x44 (last on 4th), core_ack after 10 RUN cycles -> writes to addr 0..3, core_start high 2 cycles, run_cycles=10, 32 bytes from addr 64..95, out_last on 32nd.
REQ-040 out_ready toggled 1/0 every cycle during DUMP -> out_data/out_last stable while stalled, exactly 32 transfers, then busy=0.
REQ-041 TIMEOUT=20, core_ack held 0 -> timeout=1, run_cycles=20, DUMP still completes.
REQ-042 TIMEOUT=20, core_ack rises exactly at run_cycles=20 -> timeout=0, DUMP entered.
REQ-043 Reset=0 asserted mid-RUN and mid-DUMP -> next cycle IDLE, all outputs 0, new load accepted normally.
REQ-044 Load 258 bytes -> writes wrap, bytes 257-258 land at addr 0 and 1.
